// File: rtl/reg_file.sv
// Architectural register file with rename tags for a RoB-based out-of-order core.
//
// Each architectural register holds a 32-bit committed value and a rename tag.
// Tag 0 means the value is ready; a nonzero tag names the RoB entry that will
// produce the register's next value. Entry 0 (x0) always reads value 0, tag 0.
//
// Ports:
//   clk_in                     system clock, rising edge
//   rst_in                     asynchronous active-high reset, clears all entries
//   rdy_in                     global enable; when low, all state holds
//   commit_flag_from_rob       commit strobe from the RoB head
//   rd_from_rob                destination register of the committing instruction
//   Q_from_rob                 RoB id of the committing instruction
//   V_from_rob                 committed result
//   rollback_flag_from_rob     mispredict flush; clears every tag
//   rename_en_from_dispatcher  dispatcher allocates a new producer
//   rename_rd_from_dispatcher  register being renamed
//   rename_Q_from_dispatcher   new tag for that register
//   rs1/rs2_from_dispatcher    source register indices
//   Q1/Q2_to_dispatcher        source tags (combinational)
//   V1/V2_to_dispatcher        source values (combinational)
module reg_file #(
  parameter int unsigned REG_NUM = 32,
  parameter int unsigned TAG_W   = 5
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             commit_flag_from_rob,
  input  logic [4:0]       rd_from_rob,
  input  logic [TAG_W-1:0] Q_from_rob,
  input  logic [31:0]      V_from_rob,
  input  logic             rollback_flag_from_rob,
  input  logic             rename_en_from_dispatcher,
  input  logic [4:0]       rename_rd_from_dispatcher,
  input  logic [TAG_W-1:0] rename_Q_from_dispatcher,
  input  logic [4:0]       rs1_from_dispatcher,
  input  logic [4:0]       rs2_from_dispatcher,
  output logic [TAG_W-1:0] Q1_to_dispatcher,
  output logic [TAG_W-1:0] Q2_to_dispatcher,
  output logic [31:0]      V1_to_dispatcher,
  output logic [31:0]      V2_to_dispatcher
);

  logic [31:0]      r_value [REG_NUM];
  logic [TAG_W-1:0] r_tag   [REG_NUM];

  // An index is writable/readable only if nonzero and inside the array.
  logic w_commit_ok;
  logic w_rename_ok;
  logic w_rs1_ok;
  logic w_rs2_ok;

  assign w_commit_ok = commit_flag_from_rob && (rd_from_rob != 5'd0) &&
                       (32'(rd_from_rob) < REG_NUM);
  assign w_rename_ok = rename_en_from_dispatcher && (rename_rd_from_dispatcher != 5'd0) &&
                       (32'(rename_rd_from_dispatcher) < REG_NUM);
  assign w_rs1_ok    = (rs1_from_dispatcher != 5'd0) && (32'(rs1_from_dispatcher) < REG_NUM);
  assign w_rs2_ok    = (rs2_from_dispatcher != 5'd0) && (32'(rs2_from_dispatcher) < REG_NUM);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < int'(REG_NUM); i++) begin
        r_value[i] <= '0;
        r_tag[i]   <= '0;
      end
    end else if (rdy_in) begin
      if (w_commit_ok) begin
        r_value[rd_from_rob] <= V_from_rob;
        // Only clear the tag if no younger producer has renamed rd since.
        if ((r_tag[rd_from_rob] == Q_from_rob) && (Q_from_rob != '0)) begin
          r_tag[rd_from_rob] <= '0;
        end
      end
      // Later assignments win: rollback beats everything, rename beats commit clear.
      if (rollback_flag_from_rob) begin
        for (int i = 0; i < int'(REG_NUM); i++) begin
          r_tag[i] <= '0;
        end
      end else if (w_rename_ok) begin
        r_tag[rename_rd_from_dispatcher] <= rename_Q_from_dispatcher;
      end
    end
  end

  // Reads: committing value is forwarded when it resolves the current tag.
  // Same-cycle renames are deliberately not forwarded. Outputs are forced to 0
  // during reset so the bypass cannot leak V_from_rob.
  always_comb begin
    Q1_to_dispatcher = '0;
    V1_to_dispatcher = '0;
    Q2_to_dispatcher = '0;
    V2_to_dispatcher = '0;
    if (!rst_in && w_rs1_ok) begin
      if (commit_flag_from_rob && (rd_from_rob == rs1_from_dispatcher) &&
          (r_tag[rs1_from_dispatcher] == Q_from_rob)) begin
        V1_to_dispatcher = V_from_rob;
      end else begin
        Q1_to_dispatcher = r_tag[rs1_from_dispatcher];
        V1_to_dispatcher = r_value[rs1_from_dispatcher];
      end
    end
    if (!rst_in && w_rs2_ok) begin
      if (commit_flag_from_rob && (rd_from_rob == rs2_from_dispatcher) &&
          (r_tag[rs2_from_dispatcher] == Q_from_rob)) begin
        V2_to_dispatcher = V_from_rob;
      end else begin
        Q2_to_dispatcher = r_tag[rs2_from_dispatcher];
        V2_to_dispatcher = r_value[rs2_from_dispatcher];
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        commit_flag_from_rob;
  logic [4:0]  rd_from_rob;
  logic [4:0]  Q_from_rob;
  logic [31:0] V_from_rob;
  logic        rollback_flag_from_rob;
  logic        rename_en_from_dispatcher;
  logic [4:0]  rename_rd_from_dispatcher;
  logic [4:0]  rename_Q_from_dispatcher;
  logic [4:0]  rs1_from_dispatcher;
  logic [4:0]  rs2_from_dispatcher;
  logic [4:0]  Q1_to_dispatcher;
  logic [4:0]  Q2_to_dispatcher;
  logic [31:0] V1_to_dispatcher;
  logic [31:0] V2_to_dispatcher;

  reg_file #(.REG_NUM(32), .TAG_W(5)) dut (
    .clk_in                    (clk_in),
    .rst_in                    (rst_in),
    .rdy_in                    (rdy_in),
    .commit_flag_from_rob      (commit_flag_from_rob),
    .rd_from_rob               (rd_from_rob),
    .Q_from_rob                (Q_from_rob),
    .V_from_rob                (V_from_rob),
    .rollback_flag_from_rob    (rollback_flag_from_rob),
    .rename_en_from_dispatcher (rename_en_from_dispatcher),
    .rename_rd_from_dispatcher (rename_rd_from_dispatcher),
    .rename_Q_from_dispatcher  (rename_Q_from_dispatcher),
    .rs1_from_dispatcher       (rs1_from_dispatcher),
    .rs2_from_dispatcher       (rs2_from_dispatcher),
    .Q1_to_dispatcher          (Q1_to_dispatcher),
    .Q2_to_dispatcher          (Q2_to_dispatcher),
    .V1_to_dispatcher          (V1_to_dispatcher),
    .V2_to_dispatcher          (V2_to_dispatcher)
  );

  always #5 clk_in = ~clk_in;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Reference architectural state.
  logic [31:0] m_val [32];
  logic [4:0]  m_tag [32];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0;
      m_tag[i] = '0;
    end
  endtask

  // What a source read should return given current model state and inputs.
  function automatic void exp_read(input logic [4:0] rs, output logic [4:0] q,
                                   output logic [31:0] v);
    if (rs == 5'd0) begin
      q = '0; v = '0;
    end else if (commit_flag_from_rob && rd_from_rob == rs && m_tag[rs] == Q_from_rob) begin
      q = '0; v = V_from_rob;
    end else begin
      q = m_tag[rs]; v = m_val[rs];
    end
  endfunction

  task automatic check_reads(input string tag);
    logic [4:0]  q;
    logic [31:0] v;
    exp_read(rs1_from_dispatcher, q, v);
    check_eq({tag, ".Q1"}, 32'(Q1_to_dispatcher), 32'(q));
    check_eq({tag, ".V1"}, V1_to_dispatcher, v);
    exp_read(rs2_from_dispatcher, q, v);
    check_eq({tag, ".Q2"}, 32'(Q2_to_dispatcher), 32'(q));
    check_eq({tag, ".V2"}, V2_to_dispatcher, v);
  endtask

  // Advance one clock edge, updating the model from the inputs held across it.
  task automatic tick();
    logic [31:0] nv [32];
    logic [4:0]  nt [32];
    for (int i = 0; i < 32; i++) begin
      nv[i] = m_val[i];
      nt[i] = m_tag[i];
    end
    if (rdy_in) begin
      if (commit_flag_from_rob && rd_from_rob != 0) begin
        nv[rd_from_rob] = V_from_rob;
        if (m_tag[rd_from_rob] == Q_from_rob && Q_from_rob != 0) nt[rd_from_rob] = '0;
      end
      if (rollback_flag_from_rob) begin
        for (int i = 0; i < 32; i++) nt[i] = '0;
      end else if (rename_en_from_dispatcher && rename_rd_from_dispatcher != 0) begin
        nt[rename_rd_from_dispatcher] = rename_Q_from_dispatcher;
      end
    end
    @(posedge clk_in);
    for (int i = 0; i < 32; i++) begin
      m_val[i] = nv[i];
      m_tag[i] = nt[i];
    end
    #1;
  endtask

  task automatic idle();
    rdy_in                    = 1'b1;
    commit_flag_from_rob      = 1'b0;
    rd_from_rob               = '0;
    Q_from_rob                = '0;
    V_from_rob                = '0;
    rollback_flag_from_rob    = 1'b0;
    rename_en_from_dispatcher = 1'b0;
    rename_rd_from_dispatcher = '0;
    rename_Q_from_dispatcher  = '0;
    rs1_from_dispatcher       = '0;
    rs2_from_dispatcher       = '0;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [4:0] q);
    idle();
    rename_en_from_dispatcher = 1'b1;
    rename_rd_from_dispatcher = rd;
    rename_Q_from_dispatcher  = q;
    tick();
  endtask

  initial begin
    model_clear();
    idle();
    rst_in = 1'b1;
    // Bypass-looking inputs during reset must still read as zero.
    commit_flag_from_rob = 1'b1;
    rd_from_rob          = 5'd3;
    V_from_rob           = 32'hDEAD_BEEF;
    rs1_from_dispatcher  = 5'd3;
    rs2_from_dispatcher  = 5'd3;
    #3;
    check_eq("rst.Q1", 32'(Q1_to_dispatcher), 32'd0);
    check_eq("rst.V1", V1_to_dispatcher, 32'd0);
    check_eq("rst.V2", V2_to_dispatcher, 32'd0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    idle();
    for (int i = 0; i < 32; i++) begin
      rs1_from_dispatcher = 5'(i);
      rs2_from_dispatcher = 5'(31 - i);
      #1;
      check_reads("reset_state");
    end

    // Rename then commit clears the tag and exposes the value.
    rename(5'd5, 5'd3);
    idle();
    commit_flag_from_rob = 1'b1; rd_from_rob = 5'd5; Q_from_rob = 5'd3;
    V_from_rob = 32'h1234;
    tick();
    idle(); rs1_from_dispatcher = 5'd5; #1;
    check_eq("ren_commit.Q1", 32'(Q1_to_dispatcher), 32'd0);
    check_eq("ren_commit.V1", V1_to_dispatcher, 32'h1234);

    // Stale commit keeps the newer tag.
    rename(5'd5, 5'd3);
    rename(5'd5, 5'd7);
    idle();
    commit_flag_from_rob = 1'b1; rd_from_rob = 5'd5; Q_from_rob = 5'd3; V_from_rob = 32'hAA;
    tick();
    idle(); rs1_from_dispatcher = 5'd5; #1;
    check_eq("stale.Q1", 32'(Q1_to_dispatcher), 32'd7);
    check_eq("stale.V1", V1_to_dispatcher, 32'hAA);

    // Bypass plus same-register rename collision.
    rename(5'd6, 5'd4);
    idle();
    commit_flag_from_rob = 1'b1; rd_from_rob = 5'd6; Q_from_rob = 5'd4; V_from_rob = 32'h55;
    rs2_from_dispatcher = 5'd6;
    rename_en_from_dispatcher = 1'b1; rename_rd_from_dispatcher = 5'd6;
    rename_Q_from_dispatcher = 5'd9;
    #1;
    check_eq("bypass.Q2", 32'(Q2_to_dispatcher), 32'd0);
    check_eq("bypass.V2", V2_to_dispatcher, 32'h55);
    tick();
    idle(); rs2_from_dispatcher = 5'd6; #1;
    check_eq("collide.Q2", 32'(Q2_to_dispatcher), 32'd9);
    check_eq("collide.V2", V2_to_dispatcher, 32'h55);

    // Rollback with commit and rename in the same edge.
    rename(5'd1, 5'd2);
    rename(5'd2, 5'd3);
    idle();
    rollback_flag_from_rob = 1'b1;
    commit_flag_from_rob = 1'b1; rd_from_rob = 5'd1; Q_from_rob = 5'd2; V_from_rob = 32'h10;
    rename_en_from_dispatcher = 1'b1; rename_rd_from_dispatcher = 5'd4;
    rename_Q_from_dispatcher = 5'd5;
    tick();
    idle(); rs1_from_dispatcher = 5'd1; rs2_from_dispatcher = 5'd2; #1;
    check_eq("rollback.Q1", 32'(Q1_to_dispatcher), 32'd0);
    check_eq("rollback.V1", V1_to_dispatcher, 32'h10);
    check_eq("rollback.Q2", 32'(Q2_to_dispatcher), 32'd0);
    rs1_from_dispatcher = 5'd4; rs2_from_dispatcher = 5'd6; #1;
    check_eq("rollback.Q4", 32'(Q1_to_dispatcher), 32'd0);
    check_eq("rollback.Q6", 32'(Q2_to_dispatcher), 32'd0);

    // x0 ignores writes; stall holds state.
    idle();
    commit_flag_from_rob = 1'b1; rd_from_rob = 5'd0; V_from_rob = 32'hFFFF;
    rename_en_from_dispatcher = 1'b1; rename_rd_from_dispatcher = 5'd0;
    rename_Q_from_dispatcher = 5'd6;
    tick();
    idle(); #1;
    check_eq("x0.Q1", 32'(Q1_to_dispatcher), 32'd0);
    check_eq("x0.V1", V1_to_dispatcher, 32'd0);
    idle(); rdy_in = 1'b0;
    commit_flag_from_rob = 1'b1; rd_from_rob = 5'd3; V_from_rob = 32'hBEEF;
    rename_en_from_dispatcher = 1'b1; rename_rd_from_dispatcher = 5'd3;
    rename_Q_from_dispatcher = 5'd2;
    rs1_from_dispatcher = 5'd3; #1;
    // Tag[3] is 0 and Q is 0, so the bypass still forwards while stalled.
    check_eq("stall_bypass.V1", V1_to_dispatcher, 32'hBEEF);
    tick();
    idle(); rs1_from_dispatcher = 5'd3; #1;
    check_eq("stall.V3", V1_to_dispatcher, 32'd0);
    check_eq("stall.Q3", 32'(Q1_to_dispatcher), 32'd0);

    // Randomized traffic on a small register window to force collisions.
    for (int n = 0; n < 400; n++) begin
      idle();
      rdy_in                    = ($urandom % 8) != 0;
      commit_flag_from_rob      = $urandom % 2;
      rd_from_rob               = 5'($urandom_range(0, 7));
      Q_from_rob                = ($urandom % 3 == 0) ? m_tag[rd_from_rob]
                                                      : 5'($urandom_range(0, 16));
      V_from_rob                = $urandom;
      rollback_flag_from_rob    = ($urandom % 16) == 0;
      rename_en_from_dispatcher = $urandom % 2;
      rename_rd_from_dispatcher = 5'($urandom_range(0, 7));
      rename_Q_from_dispatcher  = 5'($urandom_range(1, 16));
      rs1_from_dispatcher       = 5'($urandom_range(0, 7));
      rs2_from_dispatcher       = ($urandom % 2) ? rd_from_rob : 5'($urandom_range(0, 7));
      #1;
      check_reads("rand");
      tick();
    end

    // Async reset mid-cycle with live state.
    rename(5'd5, 5'd11);
    idle();
    commit_flag_from_rob = 1'b1; rd_from_rob = 5'd2; V_from_rob = 32'hCAFE;
    tick();
    idle(); rs1_from_dispatcher = 5'd2; rs2_from_dispatcher = 5'd5; #1;
    check_reads("pre_reset");
    #2;
    rst_in = 1'b1;
    #1;
    check_eq("async_rst.V1", V1_to_dispatcher, 32'd0);
    check_eq("async_rst.Q2", 32'(Q2_to_dispatcher), 32'd0);
    model_clear();
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    #1;
    check_reads("post_reset");
    rename(5'd2, 5'd8);
    idle(); rs1_from_dispatcher = 5'd2; #1;
    check_eq("post_reset_ren.Q1", 32'(Q1_to_dispatcher), 32'd8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have parameter REG_NUM, default 32, meaning the number of architectural registers; x0 is hardwired to zero.
REQ-002 The block SHALL have parameter TAG_W, default 5, meaning the rename-tag width; tag 0 means "value ready", tags 1..16 are RoB entry ids.
REQ-003 The block SHALL have ports: clk_in  input  1  system clock, rising edge.
REQ-004 The block SHALL have ports: rst_in  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have ports: rdy_in  input  1  global enable; when low, all state holds.
REQ-006 The block SHALL have ports: commit_flag_from_rob  input  1  commit strobe from the RoB head.
REQ-007 The block SHALL have ports: rd_from_rob  input  5  destination register of the committing instruction.
REQ-008 The block SHALL have ports: Q_from_rob  input  5  RoB id (1..16) of the committing instruction.
REQ-009 The block SHALL have ports: V_from_rob  input  32  committed result.
REQ-010 The block SHALL have ports: rollback_flag_from_rob  input  1  mispredict flush.
REQ-011 The block SHALL have ports: rename_en_from_dispatcher  input  1  dispatcher allocates a new producer.
REQ-012 The block SHALL have ports: rename_rd_from_dispatcher  input  5, and rename_Q_from_dispatcher  input  5: register and new tag.
REQ-013 The block SHALL have ports: rs1_from_dispatcher, rs2_from_dispatcher  input  5  source register indices.
REQ-014 The block SHALL have ports: Q1_to_dispatcher, Q2_to_dispatcher  output  5  source tags; V1_to_dispatcher, V2_to_dispatcher  output  32  source values.

Function
REQ-015 Storage SHALL be value[REG_NUM] (32 bit) and tag[REG_NUM] (TAG_W bit); entry 0 SHALL read value 0, tag 0 at all times and SHALL ignore all writes.
REQ-016 Commit: on a rising edge with rdy_in=1, commit_flag=1, rd!=0, the block SHALL write value[rd] <= V_from_rob.
REQ-017 Commit tag clear: in the same edge, tag[rd] SHALL become 0 only if tag[rd]==Q_from_rob and Q_from_rob!=0; otherwise the newer tag SHALL be kept.
REQ-018 Rename: on a rising edge with rdy_in=1, rename_en=1, rename_rd!=0, rollback=0, the block SHALL write tag[rename_rd] <= rename_Q.
REQ-019 Same-register commit and rename in one edge: the rename tag SHALL win; the value write SHALL still occur.
REQ-020 Rollback: on a rising edge with rdy_in=1, rollback_flag=1, all tags SHALL become 0; any rename in that edge SHALL be dropped; a simultaneous commit value write SHALL still occur.
REQ-021 Read ports SHALL be combinational, with zero-cycle latency.
REQ-022 Commit bypass: if commit_flag=1, rd_from_rob==rsN, rsN!=0, and tag[rsN]==Q_from_rob, then the outputs SHALL be QN=0 and VN=V_from_rob.
REQ-023 Reads SHALL otherwise return QN=tag[rsN], VN=value[rsN].
REQ-024 Same-cycle rename SHALL NOT be bypassed to the reads, so that an instruction with rs==rd sees the prior producer.
REQ-025 With rdy_in=0, no storage SHALL change, and reads SHALL remain valid, with the bypass still active.

Reset
REQ-026 Asserting rst_in SHALL immediately clear all value and tag entries to 0, independent of clk_in and rdy_in.
REQ-027 During reset, all outputs SHALL read Q=0 and V=0.
REQ-028 Reset SHALL override any commit, rename or rollback in progress.
REQ-029 After rst_in deasserts, the first rising edge SHALL process inputs normally.

Verification
REQ-030 Rename then commit: rename x5->tag 3; commit rd=5, Q=3, V=0x1234 -> next cycle rs1=5 reads Q1=0, V1=0x1234.
REQ-031 Stale commit: rename x5->3, then rename x5->7, then commit rd=5, Q=3, V=0xAA -> value[5]=0xAA and tag stays 7; rs1=5 reads Q1=7.
REQ-032 Bypass and collision: with tag[6]=4, drive commit rd=6, Q=4, V=0x55 and rs2=6 in the same cycle -> Q2=0, V2=0x55 combinationally; with simultaneous rename x6->9 -> tag[6]=9 after the edge.
REQ-033 Rollback: tags x1=2, x2=3; assert rollback with commit rd=1, Q=2, V=0x10 and rename x4->5 -> all tags 0, value[1]=0x10, tag[4]=0.
REQ-034 x0 and stall: commit rd=0, V=0xFFFF and rename x0->6 -> rs1=0 reads Q1=0, V1=0; with rdy_in=0, commit rd=3 -> value[3] unchanged.
REQ-035 Async reset: assert rst_in mid-cycle with nonzero state -> all reads return 0 before the next clock edge.
